// File: rtl/i2c_reg16_pkg.sv
// Shared state encoding, bus-event bundle and constants for the I2C 16-bit-register target.
package i2c_reg16_pkg;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h10;
  localparam int         BIT_CNT          = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DEV,
    S_ACK_DEV,
    S_REG_HI,
    S_ACK_HI,
    S_REG_LO,
    S_ACK_LO,
    S_WDATA,
    S_ACK_W,
    S_RDATA,
    S_MACK,
    S_WAIT
  } state_t;

  // One-cycle bus events plus the synchronized SDA level aligned with them.
  typedef struct packed {
    logic start;
    logic stop;
    logic scl_rise;
    logic scl_fall;
    logic sda;
  } bus_evt_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Pad synchronizers and START/STOP/SCL-edge pulse generation; pad-to-event latency 3 clk, no backpressure.
// Synchronizer flops run through reset so a mid-transfer reset never fabricates an edge.
module i2c_bus_sync
  import i2c_reg16_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     scl_in,
  input  logic     sda_in,
  output bus_evt_t evt
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;

  always_ff @(posedge clk) begin
    scl_sync <= {scl_sync[0], scl_in};
    sda_sync <= {sda_sync[0], sda_in};
    scl_d    <= scl_sync[1];
    sda_d    <= sda_sync[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt <= '0;
    end else begin
      evt.scl_rise <= scl_sync[1] & ~scl_d;
      evt.scl_fall <= ~scl_sync[1] & scl_d;
      evt.start    <= scl_sync[1] & scl_d & sda_d & ~sda_sync[1];
      evt.stop     <= scl_sync[1] & scl_d & ~sda_d & sda_sync[1];
      evt.sda      <= sda_sync[1];
    end
  end

endmodule

// File: rtl/i2c_reg16_target.sv
// I2C target: 7-bit dev addr, 16-bit reg pointer with auto-increment, writes out on a 1-clk strobe; reads need I2C_REG16_TARGET_READ_EN.
// wr_en follows the internal SCL rise of bit 8 by 1 clk; no backpressure, the bus master paces all traffic.
module i2c_reg16_target
  import i2c_reg16_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy
);

  bus_evt_t evt;

  i2c_bus_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .scl_in (scl_in),
    .sda_in (sda_in),
    .evt    (evt)
  );

  state_t               state, state_nxt;
  logic [BIT_CNT-1:0]   bit_cnt, bit_cnt_nxt;
  logic                 full, full_nxt;
  logic [7:0]           shreg, shreg_nxt;
  logic [7:0]           reg_hi, reg_hi_nxt;
  logic [15:0]          ptr, ptr_nxt;
  logic                 sda_oe_nxt, wr_en_nxt, busy_nxt;
  logic [15:0]          wr_addr_nxt;
  logic [7:0]           wr_data_nxt;
  logic [7:0]           rx_byte;

`ifndef I2C_REG16_TARGET_READ_EN
  logic unused_rd;
  assign unused_rd = ^rd_data;
`endif

  assign rd_addr = ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      full    <= 1'b0;
      shreg   <= '0;
      reg_hi  <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      full    <= full_nxt;
      shreg   <= shreg_nxt;
      reg_hi  <= reg_hi_nxt;
      ptr     <= ptr_nxt;
      sda_oe  <= sda_oe_nxt;
      wr_en   <= wr_en_nxt;
      wr_addr <= wr_addr_nxt;
      wr_data <= wr_data_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    full_nxt    = full;
    shreg_nxt   = shreg;
    reg_hi_nxt  = reg_hi;
    ptr_nxt     = ptr;
    sda_oe_nxt  = sda_oe;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    busy_nxt    = busy;
    rx_byte     = {shreg[6:0], evt.sda};

    // Bus conditions abort any partial byte; the pointer survives a repeated START.
    if (evt.start || evt.stop) begin
      state_nxt   = evt.start ? S_START : S_IDLE;
      bit_cnt_nxt = '0;
      full_nxt    = 1'b0;
      sda_oe_nxt  = 1'b0;
    end else begin
      case (state)
        S_START: if (evt.scl_fall) state_nxt = S_DEV;

        S_DEV, S_REG_HI, S_REG_LO, S_WDATA: begin
          if (evt.scl_rise && !full) begin
            shreg_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 1'b1;
            if (bit_cnt == '1) begin
              full_nxt = 1'b1;
              if (state == S_REG_HI) reg_hi_nxt = rx_byte;
              if (state == S_REG_LO) ptr_nxt = {reg_hi, rx_byte};
              if (state == S_WDATA) begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = ptr;
                wr_data_nxt = rx_byte;
                ptr_nxt     = ptr + 16'd1;
              end
            end
          end else if (evt.scl_fall && full) begin
            full_nxt   = 1'b0;
            sda_oe_nxt = 1'b1;
            case (state)
              S_DEV: begin
                state_nxt = S_ACK_DEV;
`ifdef I2C_REG16_TARGET_READ_EN
                if (shreg[7:1] != DEV_ADDR) begin
`else
                if (shreg[7:1] != DEV_ADDR || shreg[0]) begin
`endif
                  state_nxt  = S_WAIT;
                  sda_oe_nxt = 1'b0;
                end
              end
              S_REG_HI: state_nxt = S_ACK_HI;
              S_REG_LO: state_nxt = S_ACK_LO;
              default:  state_nxt = S_ACK_W;
            endcase
          end
        end

        S_ACK_DEV: if (evt.scl_fall) begin
          state_nxt  = S_REG_HI;
          sda_oe_nxt = 1'b0;
`ifdef I2C_REG16_TARGET_READ_EN
          if (shreg[0]) begin
            state_nxt  = S_RDATA;
            shreg_nxt  = rd_data;
            sda_oe_nxt = ~rd_data[7];
          end
`endif
        end

        S_ACK_HI: if (evt.scl_fall) begin
          state_nxt  = S_REG_LO;
          sda_oe_nxt = 1'b0;
        end

        S_ACK_LO, S_ACK_W: if (evt.scl_fall) begin
          state_nxt  = S_WDATA;
          sda_oe_nxt = 1'b0;
        end

`ifdef I2C_REG16_TARGET_READ_EN
        S_RDATA: if (evt.scl_fall) begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          shreg_nxt   = {shreg[6:0], 1'b0};
          sda_oe_nxt  = ~shreg[6];
          if (bit_cnt == '1) begin
            state_nxt  = S_MACK;
            sda_oe_nxt = 1'b0;
          end
        end

        // Pointer advances on the master ACK so rd_data has settled by the next SCL fall.
        S_MACK: begin
          if (evt.scl_rise) begin
            if (evt.sda) state_nxt = S_WAIT;
            else         ptr_nxt   = ptr + 16'd1;
          end else if (evt.scl_fall) begin
            state_nxt  = S_RDATA;
            shreg_nxt  = rd_data;
            sda_oe_nxt = ~rd_data[7];
          end
        end
`endif

        default: ;
      endcase
    end

    if (state == S_ACK_DEV) busy_nxt = 1'b1;
    if (state_nxt == S_IDLE || state_nxt == S_WAIT) busy_nxt = 1'b0;
  end

endmodule

// File: tb/tb_i2c_reg16_target.sv
// Directed + randomized bench for i2c_reg16_target: bit-banged I2C master, open-drain SDA, transaction-level model.
module tb_i2c_reg16_target;

  localparam int QTR = 6;

  logic        clk, rst, scl_m, sda_m, sda_line;
  logic        sda_oe, wr_en, busy;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data, rd_data;

  int n_assert = 0;
  int n_fail   = 0;
  int oe_cycles = 0, busy_cycles = 0, n_dbl = 0;
  logic wr_prev = 1'b0;
  logic [15:0] got_addr[$];
  logic [7:0]  got_data[$];
  logic [7:0]  tx_q[$];
  logic [15:0] exp_ptr;

  assign sda_line = sda_m & ~sda_oe;
  // Sensor register image: any address returns a fixed function of itself.
  assign rd_data  = rd_addr[15:8] ^ rd_addr[7:0] ^ 8'hD7;

  i2c_reg16_target dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (scl_m),
    .sda_in  (sda_line),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      if (wr_prev) n_dbl++;
    end
    wr_prev = wr_en;
    if (sda_oe) oe_cycles++;
    if (busy) busy_cycles++;
  end

  function automatic logic [7:0] sensor_byte(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'hD7;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (QTR) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; q(); scl_m = 1'b1; q(); q(); scl_m = 1'b0; q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; q(); scl_m = 1'b1; q(); b = sda_line; q(); scl_m = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~mack);
  endtask

  // Full write transaction of tx_q to register ra; model: byte i lands at (ra + i) mod 2^16.
  task automatic write_txn(input string tag, input logic [6:0] dev, input logic [15:0] ra);
    int base, oe0, bz0;
    logic ack, hit;
    logic [15:0] a;
    hit  = (dev == 7'h10);
    base = got_addr.size();
    oe0  = oe_cycles;
    bz0  = busy_cycles;
    i2c_start();
    write_byte({dev, 1'b0}, ack);
    check($sformatf("%s.dev_ack", tag), ack, hit);
    if (hit) begin
      write_byte(ra[15:8], ack);
      check($sformatf("%s.reg_hi_ack", tag), ack, 1);
      write_byte(ra[7:0], ack);
      check($sformatf("%s.reg_lo_ack", tag), ack, 1);
      foreach (tx_q[i]) begin
        write_byte(tx_q[i], ack);
        check($sformatf("%s.d%0d_ack", tag, i), ack, 1);
      end
      exp_ptr = ra + 16'(tx_q.size());
    end
    i2c_stop();
    q();
    check($sformatf("%s.n_wr", tag), got_addr.size() - base, hit ? tx_q.size() : 0);
    a = ra;
    for (int i = 0; i < tx_q.size() && base + i < got_addr.size(); i++) begin
      check($sformatf("%s.wr_addr%0d", tag, i), got_addr[base+i], a);
      check($sformatf("%s.wr_data%0d", tag, i), got_data[base+i], tx_q[i]);
      a = a + 16'd1;
    end
    check($sformatf("%s.busy_seen", tag), busy_cycles != bz0, hit);
    check($sformatf("%s.oe_seen", tag), oe_cycles != oe0, hit);
    check($sformatf("%s.busy_idle", tag), busy, 0);
    check($sformatf("%s.ptr", tag), rd_addr, exp_ptr);
  endtask

  initial begin
    logic ack;
    logic [7:0] d, rb;
    logic [15:0] ra;
    logic [6:0] dev;
    int n;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; exp_ptr = 16'h0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst.sda_oe", sda_oe, 0);
    check("rst.wr_en", wr_en, 0);
    check("rst.wr_addr", wr_addr, 0);
    check("rst.wr_data", wr_data, 0);
    check("rst.rd_addr", rd_addr, 0);
    check("rst.busy", busy, 0);

    tx_q = '{8'h01};
    write_txn("single", 7'h10, 16'h0100);
    tx_q = '{8'h0D, 8'h78};
    write_txn("burst", 7'h10, 16'h0162);
    tx_q = '{8'h5C};
    write_txn("wrong_dev", 7'h36, 16'h0200);
    tx_q = '{8'hAA, 8'hBB};
    write_txn("wrap", 7'h10, 16'hFFFF);

    // Register-address write, repeated START, read.
    tx_q = {};
    i2c_start();
    write_byte(8'h20, ack);
    write_byte(8'h30, ack);
    write_byte(8'hEB, ack);
    i2c_start();
    write_byte(8'h21, ack);
    exp_ptr = 16'h30EB;
`ifdef I2C_REG16_TARGET_READ_EN
    check("read.dev_ack", ack, 1);
    read_byte(rb, 1'b0);
    check("read.data", rb, 8'h0C);
    check("read.rd_addr", rd_addr, 16'h30EB);
    i2c_stop();
    q();
    ra = 16'($urandom);
    i2c_start();
    write_byte(8'h20, ack);
    write_byte(ra[15:8], ack);
    write_byte(ra[7:0], ack);
    i2c_start();
    write_byte(8'h21, ack);
    for (int i = 0; i < 3; i++) begin
      read_byte(rb, i < 2);
      check($sformatf("rburst.data%0d", i), rb, sensor_byte(ra + 16'(i)));
    end
    exp_ptr = ra + 16'd2;
    check("rburst.rd_addr", rd_addr, exp_ptr);
`else
    check("read.dev_nack", ack, 0);
    check("read.busy_wait", busy, 0);
    check("read.rd_addr", rd_addr, 16'h30EB);
`endif
    i2c_stop();
    q();
    check("read.busy_idle", busy, 0);

    // STOP after 4 data bits: no write, pointer left at the loaded register.
    n = got_addr.size();
    i2c_start();
    write_byte(8'h20, ack);
    write_byte(8'h12, ack);
    write_byte(8'h34, ack);
    for (int i = 0; i < 4; i++) write_bit(i[0]);
    i2c_stop();
    q();
    exp_ptr = 16'h1234;
    check("abort.n_wr", got_addr.size() - n, 0);
    check("abort.ptr", rd_addr, exp_ptr);

    // Reset while the target holds the address ACK.
    d = 8'h20;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    sda_m = 1'b1; q(); scl_m = 1'b1; q();
    check("rstmid.ack_driven", sda_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.oe_released", sda_oe, 0);
    check("rstmid.ptr", rd_addr, 0);
    exp_ptr = 16'h0;
    q(); scl_m = 1'b0; q();
    write_byte(8'h20, ack);
    check("rstmid.ignored", ack, 0);
    tx_q = '{8'h55};
    write_txn("post_rst", 7'h10, 16'h0100);

    for (int t = 0; t < 8; t++) begin
      dev = ($urandom_range(0, 4) == 0) ? 7'h36 : 7'h10;
      ra  = 16'($urandom);
      n   = $urandom_range(1, 4);
      tx_q = {};
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      write_txn($sformatf("rnd%0d", t), dev, ra);
    end

    check("wr_en_single_cycle", n_dbl, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
